// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, fault causes,
// RV32I load/store funct3 encodings and an access-size helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BYTES  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    MISALIGNED   = 2'd1,
    ACCESS_FAULT = 2'd2,
    ILLEGAL      = 2'd3
  } lsu_cause_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes touched by an access; funct3[1:0] encodes the size for loads and stores.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and applies
// sign (LB/LH) or zero (LBU/LHU) extension.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted_s;

  // Lane shift followed by width-dependent extension.
  always_comb begin
    shifted_s = data_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result_o = shifted_s;
      F3_BU:   result_o = {24'h000000, shifted_s[7:0]};
      F3_HU:   result_o = {16'h0000, shifted_s[15:0]};
      default: result_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit with window, alignment and opcode checks.
// Define LSU_MISALIGNED_SPLIT_EN to execute misaligned accesses as byte sequences.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h00001000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  lsu_state_e  state_q, state_d;
  lsu_cause_e  cause_q, cause_d, in_cause_s;
  logic        we_q, we_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] align_data_s, align_out_s;
  logic [1:0]  align_off_s;
  logic        illegal_s, outside_s, misal_s;
  logic [32:0] req_end_s;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [1:0]  cnt_q, cnt_d, last_cnt_s;
  logic [31:0] asm_q, asm_d, asm_next_s, byte_addr_s;
  logic [7:0]  lane_byte_s, wr_byte_s;

  // Per-byte address, the load byte on its lane and the store byte for this step.
  always_comb begin
    byte_addr_s = addr_q + {30'h0, cnt_q};
    last_cnt_s  = 2'(access_bytes(f3_q) - 3'd1);
    case (byte_addr_s[1:0])
      2'd0:    lane_byte_s = mem_rdata[7:0];
      2'd1:    lane_byte_s = mem_rdata[15:8];
      2'd2:    lane_byte_s = mem_rdata[23:16];
      default: lane_byte_s = mem_rdata[31:24];
    endcase
    case (cnt_q)
      2'd0:    wr_byte_s = wdata_q[7:0];
      2'd1:    wr_byte_s = wdata_q[15:8];
      2'd2:    wr_byte_s = wdata_q[23:16];
      default: wr_byte_s = wdata_q[31:24];
    endcase
    asm_next_s   = asm_q | ({24'h000000, lane_byte_s} << {cnt_q, 3'b000});
    align_data_s = (state_q == BYTES) ? asm_next_s : mem_rdata;
    align_off_s  = (state_q == BYTES) ? 2'b00 : addr_q[1:0];
  end
`else
  assign align_data_s = mem_rdata;
  assign align_off_s  = addr_q[1:0];
`endif

  lsu_load_align u_align (
    .data_i   (align_data_s),
    .offset_i (align_off_s),
    .funct3_i (f3_q),
    .result_o (align_out_s)
  );

  // Classify the incoming request; illegal beats out-of-window beats misaligned.
  always_comb begin
    illegal_s = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                (req_we && req_funct3[2]);
    req_end_s = {1'b0, req_addr} + {30'h0, access_bytes(req_funct3)};
    outside_s = (req_addr < BASE_ADDR) || (req_end_s > WIN_END);
    misal_s   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (illegal_s) begin
      in_cause_s = ILLEGAL;
    end else if (outside_s) begin
      in_cause_s = ACCESS_FAULT;
    end else if (misal_s) begin
      in_cause_s = MISALIGNED;
    end else begin
      in_cause_s = NONE;
    end
  end

  // Next-state and datapath-register logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    cnt_d   = cnt_q;
    asm_d   = asm_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h00000000;
          if (in_cause_s == NONE) begin
            state_d = ACCESS;
            err_d   = 1'b0;
            cause_d = NONE;
`ifdef LSU_MISALIGNED_SPLIT_EN
          end else if (in_cause_s == MISALIGNED) begin
            state_d = BYTES;
            err_d   = 1'b0;
            cause_d = NONE;
            cnt_d   = 2'd0;
            asm_d   = 32'h00000000;
`endif
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            cause_d = in_cause_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = we_q ? 32'h00000000 : align_out_s;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BYTES: begin
        asm_d = asm_next_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_cnt_s) begin
          state_d = RESP;
          rdata_d = we_q ? 32'h00000000 : align_out_s;
        end else begin
          state_d = BYTES;
        end
      end
`endif
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h00000000;
      wdata_q <= 32'h00000000;
      rdata_q <= 32'h00000000;
      err_q   <= 1'b0;
      cause_q <= NONE;
`ifdef LSU_MISALIGNED_SPLIT_EN
      cnt_q   <= 2'd0;
      asm_q   <= 32'h00000000;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
`endif
    end
  end

  // Memory port decoded from state only, so reset silences it without waiting for a clock.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_addr   = 32'h00000000;
    mem_wdata  = 32'h00000000;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    case (state_q)
      ACCESS: begin
        mem_addr = addr_q;
        mem_we   = we_q;
        case (f3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BYTES: begin
        mem_addr  = byte_addr_s;
        mem_we    = we_q;
        mem_be    = 4'b0001 << byte_addr_s[1:0];
        mem_wdata = {4{wr_byte_s}};
      end
`endif
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign resp_cause = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-enabled memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;

  logic [31:0] mem [0:1023] = '{default: 32'h00000000};
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int failures = 0;
  int be_total = 0;
  int we_total = 0;
  logic [3:0] be_log [0:63];

  logic [31:0] t_rd;
  logic        t_err;
  logic [1:0]  t_cause;
  int          t_lat, t_nbe, t_b0, t_nwe;
  logic [31:0] hold_rd;
  int          we_snap;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_cause(resp_cause),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = 32'h00000000;
    if (mem_addr >= 32'h00001000 && mem_addr < 32'h00002000) mem_rdata = mem[mem_addr[11:2]];
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we && mem_addr >= 32'h00001000 && mem_addr < 32'h00002000) begin
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_be != 4'b0000 || mem_we) begin
      be_log[be_total[5:0]] <= mem_be;
      be_total <= be_total + 1;
    end
    if (mem_we) we_total <= we_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    int we0;
    t_b0 = be_total;
    we0  = we_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    t_lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && t_lat < 20) begin
      @(posedge clk);
      t_lat++;
      @(negedge clk);
    end
    t_rd = resp_rdata; t_err = resp_err; t_cause = resp_cause;
    t_nbe = be_total - t_b0;
    t_nwe = we_total - we0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input logic [31:0] rd, input logic err,
                            input logic [1:0] cause, input int lat, input int nbe);
    check_eq({tag, "_rdata"}, t_rd, rd);
    check_eq({tag, "_err"}, 32'(t_err), 32'(err));
    check_eq({tag, "_cause"}, 32'(t_cause), 32'(cause));
    check_eq({tag, "_lat"}, 32'(t_lat), 32'(lat));
    check_eq({tag, "_nbe"}, 32'(t_nbe), 32'(nbe));
  endtask

  function automatic logic [31:0] be_at(input int n);
    int idx;
    idx = t_b0 + n;
    return 32'(be_log[idx[5:0]]);
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    pl_en = 1'b0; pl_idx = 10'h0; pl_data = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;

    run_txn(1'b1, F3_W, 32'h00001004, 32'hDEADBEEF);
    expect_txn("sw_1004", 32'h0, 1'b0, 2'd0, 2, 1);
    check_eq("sw_1004_be", be_at(0), 32'hF);
    check_eq("sw_1004_mem", mem[1], 32'hDEADBEEF);
    run_txn(1'b0, F3_W, 32'h00001004, 32'h0);
    expect_txn("lw_1004", 32'hDEADBEEF, 1'b0, 2'd0, 2, 1);
    check_eq("lw_1004_be", be_at(0), 32'hF);

    preload(10'd2, 32'h000080FF);
    run_txn(1'b0, F3_B, 32'h00001008, 32'h0);  expect_txn("lb_1008", 32'hFFFFFFFF, 1'b0, 2'd0, 2, 1);
    run_txn(1'b0, F3_BU, 32'h00001008, 32'h0); expect_txn("lbu_1008", 32'h000000FF, 1'b0, 2'd0, 2, 1);
    run_txn(1'b0, F3_H, 32'h00001008, 32'h0);  expect_txn("lh_1008", 32'hFFFF80FF, 1'b0, 2'd0, 2, 1);
    check_eq("lh_1008_be", be_at(0), 32'h3);
    run_txn(1'b0, F3_HU, 32'h00001008, 32'h0); expect_txn("lhu_1008", 32'h000080FF, 1'b0, 2'd0, 2, 1);
    run_txn(1'b0, F3_B, 32'h00001009, 32'h0);  expect_txn("lb_1009", 32'hFFFFFF80, 1'b0, 2'd0, 2, 1);
    check_eq("lb_1009_be", be_at(0), 32'h2);
    run_txn(1'b0, F3_HU, 32'h0000100A, 32'h0); expect_txn("lhu_100a", 32'h0, 1'b0, 2'd0, 2, 1);
    check_eq("lhu_100a_be", be_at(0), 32'hC);

    run_txn(1'b1, F3_B, 32'h0000100D, 32'h123456AB);
    expect_txn("sb_100d", 32'h0, 1'b0, 2'd0, 2, 1);
    check_eq("sb_100d_be", be_at(0), 32'h2);
    run_txn(1'b1, F3_H, 32'h0000100E, 32'h0000BEEF);
    check_eq("sh_100e_be", be_at(0), 32'hC);
    check_eq("sh_100e_mem", mem[3], 32'hBEEFAB00);

    run_txn(1'b0, F3_W, 32'h00001FFC, 32'h0);  expect_txn("lw_1ffc", 32'h0, 1'b0, 2'd0, 2, 1);
    run_txn(1'b0, F3_W, 32'h00000FFC, 32'h0);  expect_txn("lw_0ffc", 32'h0, 1'b1, 2'd2, 1, 0);
    run_txn(1'b1, F3_W, 32'h00002000, 32'h5);  expect_txn("sw_2000", 32'h0, 1'b1, 2'd2, 1, 0);
    check_eq("sw_2000_nwe", 32'(t_nwe), 32'd0);
    run_txn(1'b0, F3_H, 32'h00001FFF, 32'h0);  expect_txn("lh_1fff", 32'h0, 1'b1, 2'd2, 1, 0);
    run_txn(1'b0, 3'b011, 32'h00001000, 32'h0); expect_txn("f3_011", 32'h0, 1'b1, 2'd3, 1, 0);
    run_txn(1'b1, F3_BU, 32'h00001000, 32'h0);  expect_txn("st_f3_100", 32'h0, 1'b1, 2'd3, 1, 0);
    check_eq("st_f3_100_nwe", 32'(t_nwe), 32'd0);
    run_txn(1'b0, 3'b111, 32'h00000000, 32'h0); expect_txn("f3_111_oow", 32'h0, 1'b1, 2'd3, 1, 0);

    preload(10'd0, 32'h44332211);
    preload(10'd1, 32'h88776655);
    run_txn(1'b0, F3_W, 32'h00001002, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    expect_txn("lw_1002", 32'h66554433, 1'b0, 2'd0, 5, 4);
    check_eq("lw_1002_be0", be_at(0), 32'h4);
    check_eq("lw_1002_be1", be_at(1), 32'h8);
    check_eq("lw_1002_be2", be_at(2), 32'h1);
    check_eq("lw_1002_be3", be_at(3), 32'h2);
    run_txn(1'b0, F3_H, 32'h00001001, 32'h0);
    expect_txn("lh_1001", 32'h00003322, 1'b0, 2'd0, 3, 2);
`else
    expect_txn("lw_1002", 32'h0, 1'b1, 2'd1, 1, 0);
    run_txn(1'b0, F3_H, 32'h00001001, 32'h0);
    expect_txn("lh_1001", 32'h0, 1'b1, 2'd1, 1, 0);
`endif

    // Response held under backpressure while a competing store is offered.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h00001008;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_valid0", 32'(resp_valid), 32'd1);
    check_eq("bp_rdata0", resp_rdata, 32'h000080FF);
    hold_rd = resp_rdata;
    we_snap = we_total;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h00001008; req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
      check_eq("bp_rdata", resp_rdata, hold_rd);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    check_eq("bp_no_write", 32'(we_total - we_snap), 32'd0);
    check_eq("bp_mem", mem[2], 32'h000080FF);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("bp_back_idle", 32'(req_ready), 32'd1);

    // Reset asserted during the memory cycle of a store.
    preload(10'd4, 32'h11111111);
    run_txn(1'b0, 3'b110, 32'h00001000, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h00001010; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rs_mem_we_pre", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rs_mem_we", 32'(mem_we), 32'd0);
    check_eq("rs_mem_be", 32'(mem_be), 32'd0);
    check_eq("rs_mem_addr", mem_addr, 32'h0);
    check_eq("rs_mem_wdata", mem_wdata, 32'h0);
    check_eq("rs_req_ready", 32'(req_ready), 32'd1);
    check_eq("rs_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rs_resp_err", 32'(resp_err), 32'd0);
    check_eq("rs_resp_cause", 32'(resp_cause), 32'd0);
    check_eq("rs_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rs_mem_kept", mem[4], 32'h11111111);
    run_txn(1'b0, F3_W, 32'h00001010, 32'h0);
    expect_txn("rs_recover", 32'h11111111, 1'b0, 2'd0, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00001000, meaning data-memory window base byte address.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning window size in 32-bit words.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=store), req_funct3 in 3 (RV32I load/store funct3), req_addr in 32, req_wdata in 32.
REQ-006 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out 32, resp_err out 1, resp_cause out 2.
REQ-007 SHALL have ports mem_addr out 32 (byte address), mem_wdata out 32, mem_we out 1, mem_be out 4, mem_rdata in 32 (combinational read, synchronous write memory).

Function
REQ-008 SHALL implement states IDLE, ACCESS, BYTES, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL accept a request on req_valid&&req_ready, latching we, funct3, addr, wdata.
REQ-010 SHALL classify the latched request in order: illegal op (funct3 011/110/111, or 100/101 with we=1) cause 3; out-of-window (any byte outside [BASE_ADDR, BASE_ADDR+DEPTH*4)) cause 2; misaligned (half addr[0]!=0, word addr[1:0]!=0) cause 1.
REQ-011 SHALL go IDLE->RESP for any faulting request with resp_err=1, resp_rdata=0, no memory cycle (mem_we never asserted).
REQ-012 SHALL go IDLE->ACCESS for an aligned legal request; in ACCESS drive mem_addr=addr, mem_be=lane mask (byte 1<<addr[1:0], half 4'b0011/4'b1100, word 4'b1111), mem_wdata=store data replicated into lanes, mem_we=we, for exactly one cycle, then go RESP.
REQ-013 SHALL capture mem_rdata at the end of the ACCESS cycle, shift by lane, and sign-extend (LB, LH) or zero-extend (LBU, LHU) into resp_rdata; stores return resp_rdata=0.
REQ-014 SHALL hold resp_valid=1 and all resp_* stable in RESP until resp_ready=1, then return to IDLE; total aligned latency acceptance-to-resp_valid = 2 cycles.
REQ-015 SHALL drive mem_addr=0, mem_wdata=0, mem_be=0, mem_we=0 in IDLE and RESP.
REQ-016 SHALL never emit mem_be other than 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-017 SHALL ignore req_valid outside IDLE (no queuing; back-to-back accept possible in the cycle after RESP handshake).

Reset
REQ-018 SHALL on rst_n=0 immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_cause=0, and all mem_* outputs to 0, including mid-access (an in-flight store is abandoned, mem_we drops asynchronously).

Configuration
REQ-019 SHALL, when LSU_MISALIGNED_SPLIT_EN is defined, execute misaligned in-window legal requests in state BYTES as N sequential single-byte accesses (N=2 half, 4 word), ascending address, byte counter 0..N-1, one cycle each, assembling load bytes little-endian, then extend and go RESP (latency N+1).
REQ-020 SHALL, when LSU_MISALIGNED_SPLIT_EN is undefined, omit BYTES and the counter and report misalignment as cause 1 per REQ-011.

Structure
REQ-021 SHALL place state enum, cause codes (NONE=0, MISALIGNED=1, ACCESS_FAULT=2, ILLEGAL=3) and funct3 constants in package lsu_pkg.
REQ-022 SHALL use one sub-module lsu_load_align (combinational lane shift plus sign/zero extension).

Verification
REQ-023 SHALL cover: SW addr 0x1004 wdata 0xDEADBEEF then LW 0x1004 -> mem_be=1111 one cycle, load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid two cycles after accept.
REQ-024 SHALL cover: word 0x000080FF at 0x1008; LB 0x1008 -> 0xFFFFFFFF; LBU 0x1008 -> 0x000000FF; LH 0x1008 -> 0xFFFF80FF; LHU 0x1008 -> 0x000080FF.
REQ-025 SHALL cover: LW 0x0FFC and SW 0x2000 (DEPTH=1024) -> resp_err=1, resp_cause=2, mem_we never high; funct3=3'b011 -> cause 3.
REQ-026 SHALL cover: LW 0x1002 -> without macro cause 1, no memory cycle; with macro four byte accesses (mem_be 0100,1000,0001,0010), latency 5, correct assembled data.
REQ-027 SHALL cover: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored.
REQ-028 SHALL cover: rst_n asserted during ACCESS of SW -> mem_we=0 immediately, state IDLE, all outputs at reset values.
